// File: rtl/mac_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mac_pkg : shared limits, overflow detection and width check for MAC  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mac_pkg;

  localparam int unsigned MAX_ACC_WIDTH = 128;

  typedef logic [MAX_ACC_WIDTH-1:0] wide_t;

  function automatic bit acc_width_ok(input int unsigned a_w, input int unsigned b_w,
                                      input int unsigned acc_w);
    return (acc_w >= a_w + b_w) && (acc_w <= MAX_ACC_WIDTH);
  endfunction

  // Largest representable value in w bits; callers truncate to their width.
  function automatic wide_t sat_max(input int unsigned w, input logic is_signed);
    wide_t m;
    m = (wide_t'(1) << w) - wide_t'(1);
    if (is_signed) m = m >> 1;
    return m;
  endfunction

  function automatic wide_t sat_min(input int unsigned w, input logic is_signed);
    return is_signed ? (wide_t'(1) << (w - 1)) : '0;
  endfunction

  function automatic logic ovf_detect(input logic is_signed, input logic carry,
                                      input logic a_msb, input logic b_msb,
                                      input logic s_msb);
    return is_signed ? ((a_msb == b_msb) && (s_msb != a_msb)) : carry;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mac_acc_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mac_acc_stage : guard-bit accumulate with overflow detect, sat/wrap  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mac_acc_stage
  import mac_pkg::*;
#(
  parameter int unsigned ACC_WIDTH = 40,
  parameter int unsigned SATURATE  = 0
) (
  input  logic [ACC_WIDTH-1:0] base_i,
  input  logic [ACC_WIDTH-1:0] addend_i,
  input  logic                 signed_mode_i,
  output logic [ACC_WIDTH-1:0] sum_o,
  output logic                 ovf_o
);

  logic [ACC_WIDTH:0]   w_sum_g;
  logic [ACC_WIDTH-1:0] w_lim;

  assign w_sum_g = {1'b0, base_i} + {1'b0, addend_i};

  assign ovf_o = ovf_detect(signed_mode_i, w_sum_g[ACC_WIDTH], base_i[ACC_WIDTH-1],
                            addend_i[ACC_WIDTH-1], w_sum_g[ACC_WIDTH-1]);

  // Signed overflow direction follows the (shared) operand sign; unsigned can only overflow up.
  assign w_lim = (signed_mode_i && base_i[ACC_WIDTH-1])
               ? ACC_WIDTH'(sat_min(ACC_WIDTH, 1'b1))
               : ACC_WIDTH'(sat_max(ACC_WIDTH, signed_mode_i));

  assign sum_o = ((SATURATE != 0) && ovf_o) ? w_lim : w_sum_g[ACC_WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/mac_accumulator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mac_accumulator : pipelined bias + sum(a*b) per burst, valid/ready   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int unsigned A_WIDTH   = 16,
  parameter int unsigned B_WIDTH   = 16,
  parameter int unsigned ACC_WIDTH = 40,
  parameter int unsigned SATURATE  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_WIDTH-1:0]   a,
  input  logic [B_WIDTH-1:0]   b,
  input  logic [ACC_WIDTH-1:0] bias,
  input  logic                 signed_mode,
  input  logic                 last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] result,
  output logic                 overflow
);

  localparam int unsigned P_WIDTH = A_WIDTH + B_WIDTH;

  generate
    if (!acc_width_ok(A_WIDTH, B_WIDTH, ACC_WIDTH)) begin : g_width_err
      $error("mac_accumulator: ACC_WIDTH must be >= A_WIDTH + B_WIDTH");
    end
  endgenerate

  logic                 first_q, first_d;
  logic                 burst_mode_q, burst_mode_d;
  logic                 p_valid_q, p_valid_d;
  logic [P_WIDTH-1:0]   p_prod_q, p_prod_d;
  logic                 p_last_q, p_last_d;
  logic                 p_first_q, p_first_d;
  logic                 p_mode_q, p_mode_d;
  logic [ACC_WIDTH-1:0] p_bias_q, p_bias_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 sticky_q, sticky_d;
  logic                 out_valid_q, out_valid_d;
  logic [ACC_WIDTH-1:0] result_q, result_d;
  logic                 overflow_q, overflow_d;

  logic                 w_advance, w_accept, w_mode, w_ovf;
  logic [P_WIDTH-1:0]   w_a_ext, w_b_ext, w_prod;
  logic [ACC_WIDTH-1:0] w_prod_ext, w_base, w_sum;

  assign w_advance = !out_valid_q || out_ready;
  assign w_accept  = in_valid && w_advance;
  assign in_ready  = w_advance;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign overflow  = overflow_q;

  // Mode is latched on the first beat and reused for the rest of the burst.
  assign w_mode  = first_q ? signed_mode : burst_mode_q;
  assign w_a_ext = {{B_WIDTH{w_mode & a[A_WIDTH-1]}}, a};
  assign w_b_ext = {{A_WIDTH{w_mode & b[B_WIDTH-1]}}, b};
  assign w_prod  = w_a_ext * w_b_ext;

  generate
    if (ACC_WIDTH > P_WIDTH) begin : g_ext
      assign w_prod_ext = {{(ACC_WIDTH-P_WIDTH){p_mode_q & p_prod_q[P_WIDTH-1]}}, p_prod_q};
    end else begin : g_noext
      assign w_prod_ext = p_prod_q[ACC_WIDTH-1:0];
    end
  endgenerate

  assign w_base = p_first_q ? p_bias_q : acc_q;

  mac_acc_stage #(
    .ACC_WIDTH (ACC_WIDTH),
    .SATURATE  (SATURATE)
  ) u_acc_stage (
    .base_i        (w_base),
    .addend_i      (w_prod_ext),
    .signed_mode_i (p_mode_q),
    .sum_o         (w_sum),
    .ovf_o         (w_ovf)
  );

  always_comb begin
    first_d      = first_q;
    burst_mode_d = burst_mode_q;
    p_valid_d    = p_valid_q;
    p_prod_d     = p_prod_q;
    p_last_d     = p_last_q;
    p_first_d    = p_first_q;
    p_mode_d     = p_mode_q;
    p_bias_d     = p_bias_q;
    acc_d        = acc_q;
    sticky_d     = sticky_q;
    out_valid_d  = out_valid_q;
    result_d     = result_q;
    overflow_d   = overflow_q;
    if (w_advance) begin
      p_valid_d = w_accept;
      if (w_accept) begin
        p_prod_d  = w_prod;
        p_last_d  = last;
        p_first_d = first_q;
        p_mode_d  = w_mode;
        first_d   = last;
        if (first_q) begin
          p_bias_d     = bias;
          burst_mode_d = signed_mode;
        end
      end
      out_valid_d = p_valid_q && p_last_q;
      if (p_valid_q) begin
        if (p_last_q) begin
          result_d   = w_sum;
          overflow_d = sticky_q | w_ovf;
          acc_d      = '0;
          sticky_d   = 1'b0;
        end else begin
          acc_d    = w_sum;
          sticky_d = sticky_q | w_ovf;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      first_q      <= 1'b1;
      burst_mode_q <= 1'b0;
      p_valid_q    <= 1'b0;
      p_prod_q     <= '0;
      p_last_q     <= 1'b0;
      p_first_q    <= 1'b0;
      p_mode_q     <= 1'b0;
      p_bias_q     <= '0;
      acc_q        <= '0;
      sticky_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      result_q     <= '0;
      overflow_q   <= 1'b0;
    end else begin
      first_q      <= first_d;
      burst_mode_q <= burst_mode_d;
      p_valid_q    <= p_valid_d;
      p_prod_q     <= p_prod_d;
      p_last_q     <= p_last_d;
      p_first_q    <= p_first_d;
      p_mode_q     <= p_mode_d;
      p_bias_q     <= p_bias_d;
      acc_q        <= acc_d;
      sticky_q     <= sticky_d;
      out_valid_q  <= out_valid_d;
      result_q     <= result_d;
      overflow_q   <= overflow_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mac_accumulator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mac_accumulator : three configurations against a burst-level model|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_mac_accumulator;

  logic        clk, rst, in_valid, out_ready, signed_mode, last;
  logic [15:0] a, b;
  logic [39:0] bias;
  logic [2:0]  rdy_v, ov_v, ovf_v;
  logic [39:0] res40;
  logic [31:0] res32w, res32s;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;
  bit rand_rdy = 0;

  mac_accumulator #(.A_WIDTH(16), .B_WIDTH(16), .ACC_WIDTH(40), .SATURATE(0)) u_dut40 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_v[0]), .a(a), .b(b),
    .bias(bias), .signed_mode(signed_mode), .last(last), .out_valid(ov_v[0]),
    .out_ready(out_ready), .result(res40), .overflow(ovf_v[0]));

  mac_accumulator #(.A_WIDTH(16), .B_WIDTH(16), .ACC_WIDTH(32), .SATURATE(0)) u_dut32w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_v[1]), .a(a), .b(b),
    .bias(bias[31:0]), .signed_mode(signed_mode), .last(last), .out_valid(ov_v[1]),
    .out_ready(out_ready), .result(res32w), .overflow(ovf_v[1]));

  mac_accumulator #(.A_WIDTH(16), .B_WIDTH(16), .ACC_WIDTH(32), .SATURATE(1)) u_dut32s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_v[2]), .a(a), .b(b),
    .bias(bias[31:0]), .signed_mode(signed_mode), .last(last), .out_valid(ov_v[2]),
    .out_ready(out_ready), .result(res32s), .overflow(ovf_v[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int unsigned W [3] = '{40, 32, 32};
  bit          S [3] = '{1'b0, 1'b0, 1'b1};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] act_res(input int k);
    if (k == 0) return {24'd0, res40};
    if (k == 1) return {32'd0, res32w};
    return {32'd0, res32s};
  endfunction

  function automatic logic signed [127:0] wrap(input logic signed [127:0] x,
                                               input int unsigned w, input bit sg);
    logic signed [127:0] m;
    m = x & ((128'sd1 <<< w) - 128'sd1);
    if (sg && m[w-1]) m = m - (128'sd1 <<< w);
    return m;
  endfunction

  function automatic logic signed [127:0] prod(input logic [15:0] x, input logic [15:0] y,
                                               input bit sg);
    longint px, py;
    if (sg) begin
      px = longint'($signed(x));
      py = longint'($signed(y));
    end else begin
      px = longint'(x);
      py = longint'(y);
    end
    return px * py;
  endfunction

  // Burst-level reference: exact arithmetic, range check, clamp or wrap per beat.
  logic signed [127:0] run [3];
  bit                  run_ovf [3];
  bit                  m_first = 1, m_mode = 0, exp_ov = 0, pend_v = 0;
  logic [63:0]         exp_res [3], pend_res [3];
  bit                  exp_ovf [3], pend_ovf [3];

  initial begin
    logic signed [127:0] s, hi, lo;
    for (int k = 0; k < 3; k++) begin
      run[k] = '0; run_ovf[k] = 0; exp_res[k] = '0; exp_ovf[k] = 0;
    end
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int k = 0; k < 3; k++) begin
          chk($sformatf("in_ready[%0d]", k), 64'(rdy_v[k]), 64'(!exp_ov || out_ready));
          chk($sformatf("out_valid[%0d]", k), 64'(ov_v[k]), 64'(exp_ov));
          if (exp_ov) begin
            chk($sformatf("result[%0d]", k), act_res(k), exp_res[k]);
            chk($sformatf("overflow[%0d]", k), 64'(ovf_v[k]), 64'(exp_ovf[k]));
          end
        end
      end
      if (rst) begin
        m_first = 1; exp_ov = 0; pend_v = 0;
        for (int k = 0; k < 3; k++) begin run[k] = '0; run_ovf[k] = 0; end
      end else if (!exp_ov || out_ready) begin
        exp_ov = pend_v;
        if (pend_v)
          for (int k = 0; k < 3; k++) begin exp_res[k] = pend_res[k]; exp_ovf[k] = pend_ovf[k]; end
        pend_v = 0;
        if (in_valid) begin
          if (m_first) m_mode = signed_mode;
          for (int k = 0; k < 3; k++) begin
            if (m_first) begin
              run[k] = wrap({88'd0, bias}, W[k], m_mode);
              run_ovf[k] = 0;
            end
            hi = m_mode ? (128'sd1 <<< (W[k]-1)) - 128'sd1 : (128'sd1 <<< W[k]) - 128'sd1;
            lo = m_mode ? -(128'sd1 <<< (W[k]-1)) : 128'sd0;
            s = run[k] + prod(a, b, m_mode);
            if (s > hi || s < lo) begin
              run_ovf[k] = 1;
              if (S[k]) s = (s > hi) ? hi : lo;
              else      s = wrap(s, W[k], m_mode);
            end
            run[k] = s;
          end
          m_first = last;
          if (last) begin
            pend_v = 1;
            for (int k = 0; k < 3; k++) begin
              pend_res[k] = 64'(run[k]) & ((64'd1 << W[k]) - 64'd1);
              pend_ovf[k] = run_ovf[k];
            end
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = ($urandom % 4) != 0;
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is taken.
  task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic [39:0] tbias,
                      input logic tm, input logic tl);
    bit ok;
    int n;
    n = 0;
    a = ta; b = tb; bias = tbias; signed_mode = tm; last = tl; in_valid = 1'b1;
    do begin
      @(negedge clk);
      ok = rdy_v[0];
      @(posedge clk);
      n++;
    end while (!ok && n < 200);
    if (!ok) begin
      total++; bad++;
      $display("FAIL send_timeout: got in_ready=0 want 1 within 200 cycles");
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_ov();
    bit ok;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ov_v[0]) begin ok = 1; break; end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL wait_out_valid: got 0 want 1 within 20 cycles");
    end
  endtask

  function automatic logic [15:0] pick16();
    case ($urandom % 8)
      0:       return 16'h8000;
      1:       return 16'hFFFF;
      2:       return 16'h7FFF;
      3:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    logic [39:0] rb;
    rst = 1; in_valid = 0; out_ready = 1; signed_mode = 0; last = 0;
    a = '0; b = '0; bias = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    chk_en = 1;
    @(negedge clk);
    chk("reset_out_valid", 64'(ov_v[0]), 64'd0);
    chk("reset_in_ready", 64'(rdy_v[0]), 64'd1);
    chk("reset_result", act_res(0), 64'd0);
    chk("reset_overflow", 64'(ovf_v[0]), 64'd0);
    sync();

    // Unsigned two-beat burst with latency check.
    send(16'd3, 16'd4, 40'd5, 1'b0, 1'b0);
    send(16'd10, 16'd20, 40'd5, 1'b0, 1'b1);
    @(negedge clk);
    chk("t1_valid_early", 64'(ov_v[0]), 64'd0);
    @(negedge clk);
    chk("t1_valid", 64'(ov_v[0]), 64'd1);
    chk("t1_result", act_res(0), 64'd217);
    chk("t1_overflow", 64'(ovf_v[0]), 64'd0);
    sync();

    // Signed burst, bias = -1.
    send(16'hFFFD, 16'd7, 40'hFF_FFFF_FFFF, 1'b1, 1'b0);
    send(16'd2, 16'hFFFB, 40'd0, 1'b0, 1'b1);
    wait_ov();
    chk("t2_result", act_res(0), 64'h0000_00FF_FFFF_FFE0);
    chk("t2_overflow", 64'(ovf_v[0]), 64'd0);
    sync();

    // Overflow in 32-bit configurations: wrap vs saturate.
    send(16'd4, 16'd8, 40'h00_FFFF_FFF0, 1'b0, 1'b1);
    wait_ov();
    chk("t3_res40", act_res(0), 64'h1_0000_0010);
    chk("t3_ovf40", 64'(ovf_v[0]), 64'd0);
    chk("t3_res32w", act_res(1), 64'h0000_0010);
    chk("t3_ovf32w", 64'(ovf_v[1]), 64'd1);
    chk("t3_res32s", act_res(2), 64'hFFFF_FFFF);
    chk("t3_ovf32s", 64'(ovf_v[2]), 64'd1);
    sync();

    // Backpressure: result must hold and in_ready must drop.
    out_ready = 0;
    send(16'd2, 16'd3, 40'd0, 1'b0, 1'b1);
    wait_ov();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_in_ready_low", 64'(rdy_v[0]), 64'd0);
      chk("t4_result_held", act_res(0), 64'd6);
    end
    sync();
    out_ready = 1;
    send(16'd5, 16'd5, 40'd1, 1'b0, 1'b1);
    wait_ov();
    chk("t4_next_result", act_res(0), 64'd26);
    sync();

    // Back-to-back single-beat bursts, mode toggling.
    for (int i = 0; i < 6; i++)
      send(16'(i * 1000 + 3), 16'(16'hFFF0 + i), 40'(i), 1'(i % 2), 1'b1);
    repeat (3) sync();

    // Reset in the middle of a burst.
    send(16'd7, 16'd7, 40'd0, 1'b0, 1'b0);
    send(16'd7, 16'd7, 40'd0, 1'b0, 1'b0);
    rst = 1;
    sync();
    rst = 0;
    @(negedge clk);
    chk("t6_out_valid", 64'(ov_v[0]), 64'd0);
    chk("t6_in_ready", 64'(rdy_v[0]), 64'd1);
    chk("t6_result", act_res(0), 64'd0);
    chk("t6_overflow", 64'(ovf_v[0]), 64'd0);
    sync();
    send(16'd1, 16'd1, 40'd0, 1'b0, 1'b1);
    wait_ov();
    chk("t6_after_reset", act_res(0), 64'd1);
    sync();

    // Randomized bursts with random consumer backpressure.
    rand_rdy = 1;
    for (int n = 0; n < 400; n++) begin
      repeat ($urandom % 3) sync();
      rb[31:0]  = $urandom;
      rb[39:32] = (($urandom % 4) == 0) ? 8'hFF : 8'($urandom);
      send(pick16(), pick16(), rb, 1'($urandom), (n == 399) || (($urandom % 4) == 0));
    end
    rand_rdy = 0;
    sync();
    out_ready = 1;
    repeat (6) sync();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mac_accumulator.md
# mac_accumulator

Pipelined, parametrised multiply-accumulate engine that computes bias + Σ(a·b) over a burst of operand pairs and emits one result per burst. It succeeds the combinational MAC_UNIT with a valid/ready stream interface, signed/unsigned modes, a wide accumulator and optional saturation. It sits between an operand streamer (dot-product / FIR front end) and any result consumer that may apply backpressure.

## Interface
- A_WIDTH, 16, width of operand a
- B_WIDTH, 16, width of operand b
- ACC_WIDTH, 40, accumulator/result width; must be ≥ A_WIDTH+B_WIDTH (elaboration error otherwise)
- SATURATE, 0, 1 = clamp on accumulator overflow, 0 = wrap modulo 2^ACC_WIDTH
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat
- a  in  A_WIDTH  multiplicand
- b  in  B_WIDTH  multiplier
- bias  in  ACC_WIDTH  initial accumulator value; sampled on the first beat of a burst only
- signed_mode  in  1  1 = two's-complement a, b, bias, result; sampled on the first beat of a burst only
- last  in  1  marks final beat of a burst
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  ACC_WIDTH  burst sum
- overflow  out  1  sticky: at least one accumulation in this burst overflowed

## Operation
- Beat accepted when in_valid && in_ready. First beat = first accepted beat after reset or after a beat with last=1.
- Stage P: registers product (A_WIDTH+B_WIDTH bits; signed or unsigned multiply per burst mode), last flag, and for the first beat the bias and mode.
- Stage A: product sign/zero-extended to ACC_WIDTH, added to acc (or to bias on the first beat) with one guard bit.
- Overflow: unsigned = carry out; signed = operands same sign, sum sign differs. SATURATE=1 clamps to max/min of the mode (unsigned: all ones; signed: 0x7F..F / 0x80..0); SATURATE=0 keeps low ACC_WIDTH bits. Either way overflow flag set for rest of burst.
- On stage-A accumulate of a last beat: final sum → result register, overflow → output, out_valid=1; acc and sticky flag cleared; next beat is a first beat.
- A burst of one beat is legal: result = bias + a·b.
- Backpressure: advance = !out_valid || out_ready. in_ready = advance. Stage P, stage A and the result register update only when advance; all hold otherwise. No beat is dropped or duplicated.
- result/overflow stable while out_valid && !out_ready.

## Timing
- Reset values: in_ready=1, out_valid=0, result=0, overflow=0; acc, stage-P valid, sticky flag cleared.
- Reset mid-burst: partial burst discarded, pending result discarded, next accepted beat is a first beat.
- Latency: last beat accepted at edge k → out_valid high after edge k+1 (2 cycles from presenting the beat), no stall.
- Throughput: one beat per cycle; result of burst n may be output in the same cycle beat 0 of burst n+1 is accepted.
- in_ready is combinational from out_valid/out_ready only (no path from in_valid).
- Result taken (out_valid && out_ready) in the same cycle a new result completes: new result loads, out_valid stays 1.

## Structure
- Shared package mac_pkg: saturation-limit functions (max/min for ACC_WIDTH by mode), overflow-detect function, width-check constant.
- One sub-module: mac_acc_stage (guard-bit add, overflow detect, saturate/wrap); product stage and handshake stay in top.

## Test plan
- Unsigned, SATURATE=0, bias=5, beats (3,4),(10,20) last → result=217, overflow=0, out_valid 2 cycles after last beat.
- Signed, bias=-1 (all ones), beats (-3,7),(2,-5) last → result=-32 (two's complement in 40 bits), overflow=0.
- ACC_WIDTH=32 unsigned, bias=0xFFFF_FFF0, beat (4,8) last: SATURATE=0 → result=0x0000_0010, overflow=1; SATURATE=1 → 0xFFFF_FFFF, overflow=1.
- Backpressure: out_ready=0 for 5 cycles after result → in_ready=0, result held unchanged; next burst resumes with correct sum after out_ready=1.
- Back-to-back single-beat bursts with out_ready=1, signed_mode toggling each burst → one correct result per cycle, mode applied per burst.
- Assert rst mid-burst after 2 beats → outputs at reset values next cycle; following burst (1,1) last, bias=0 → result=1.
